// File: rtl/jtframe_rst_cen.sv
// Reset sequencer and clock-enable generator fed by the PLL lock flag.
// Holds the core in reset until lock is stable, then emits /2, /4, /8 and num/den enables.
module jtframe_rst_cen #(
    parameter int unsigned HOLD_CYCLES = 1024,
    parameter int unsigned CNTW        = 11,
    parameter int unsigned FRACW       = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pll_locked,
    input  logic             soft_rst,
    input  logic [FRACW-1:0] num,
    input  logic [FRACW-1:0] den,
    output logic             rst_out,
    output logic             cen2,
    output logic             cen4,
    output logic             cen8,
    output logic             cen_frac
);

    typedef enum logic [2:0] {
        ST_WAIT = 3'b001,
        ST_HOLD = 3'b010,
        ST_RUN  = 3'b100
    } state_t;

    localparam logic [CNTW-1:0] HOLD_LAST = CNTW'(HOLD_CYCLES - 1);

    state_t            state, state_nx;
    logic [CNTW-1:0]   cnt, cnt_nx;
    logic              lock_m, lock_s;
    logic [2:0]        div, div_nx;
    logic [FRACW-1:0]  acc, acc_nx, numc;
    logic [FRACW:0]    sum;
    logic              frac_nx, run_now, run_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_m <= 1'b0;
            lock_s <= 1'b0;
            state  <= ST_WAIT;
            cnt    <= '0;
        end else begin
            lock_m <= pll_locked;
            lock_s <= lock_m;
            state  <= state_nx;
            cnt    <= cnt_nx;
        end
    end

    // Lock loss beats soft reset, which beats the normal progression.
    always_comb begin
        state_nx = state;
        cnt_nx   = '0;
        if (!lock_s) begin
            state_nx = ST_WAIT;
        end else if (soft_rst) begin
            state_nx = ST_HOLD;
        end else begin
            case (state)
                ST_WAIT: state_nx = ST_HOLD;
                ST_HOLD: begin
                    if (cnt == HOLD_LAST) state_nx = ST_RUN;
                    else                  cnt_nx   = cnt + CNTW'(1);
                end
                ST_RUN:  state_nx = ST_RUN;
                default: state_nx = ST_WAIT;
            endcase
        end
    end

    always_comb begin
        rst_out = (state != ST_RUN);
    end

    assign run_now = (state == ST_RUN);
    assign run_nx  = (state_nx == ST_RUN);

    // Enables are registered from next-state values so they clear on the same edge RUN is left.
    always_comb begin
        div_nx  = '0;
        acc_nx  = '0;
        frac_nx = 1'b0;
        numc    = (num > den) ? den : num;
        sum     = {1'b0, acc} + {1'b0, numc};
        if (run_nx) begin
            if (run_now) div_nx = div + 3'd1;
            if (den != '0) begin
                if (sum >= {1'b0, den}) begin
                    frac_nx = 1'b1;
                    acc_nx  = FRACW'(sum - {1'b0, den});
                end else begin
                    acc_nx  = sum[FRACW-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div      <= '0;
            acc      <= '0;
            cen2     <= 1'b0;
            cen4     <= 1'b0;
            cen8     <= 1'b0;
            cen_frac <= 1'b0;
        end else begin
            div      <= div_nx;
            acc      <= acc_nx;
            cen2     <= div_nx[0];
            cen4     <= &div_nx[1:0];
            cen8     <= &div_nx;
            cen_frac <= frac_nx;
        end
    end

endmodule

// File: tb/tb_jtframe_rst_cen.sv
// Scoreboard bench for jtframe_rst_cen: expected output vectors are queued per clock
// edge by the stimulus and compared by an independent monitor on the falling edge.
module tb_jtframe_rst_cen;

    localparam int unsigned HC    = 16;
    localparam int unsigned FRACW = 10;

    logic             clk = 1'b0;
    logic             rst_n, pll_locked, soft_rst;
    logic [FRACW-1:0] num, den;
    logic             rst_out, cen2, cen4, cen8, cen_frac;

    jtframe_rst_cen #(.HOLD_CYCLES(HC), .CNTW(11), .FRACW(FRACW)) dut (
        .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked), .soft_rst(soft_rst),
        .num(num), .den(den), .rst_out(rst_out), .cen2(cen2), .cen4(cen4),
        .cen8(cen8), .cen_frac(cen_frac)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned e;
        logic [4:0]  mask;
        logic [4:0]  val;
        string       tag;
    } exp_t;

    exp_t        q[$];
    int unsigned edge_cnt = 0;
    int unsigned checks   = 0;
    int unsigned errors   = 0;

    // {cen2, cen4, cen8, cen_frac} for RUN edges 1..8 with num=3, den=8
    logic [3:0] tbl [8] = '{4'b0000, 4'b1000, 4'b0001, 4'b1100,
                            4'b0000, 4'b1001, 4'b0000, 4'b1111};

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    always @(negedge clk) begin
        exp_t       x;
        logic [4:0] obs;
        obs = {rst_out, cen2, cen4, cen8, cen_frac};
        while (q.size() > 0 && q[0].e <= edge_cnt) begin
            x = q.pop_front();
            checks++;
            if (x.e < edge_cnt) begin
                errors++;
                $display("FAIL %s: edge %0d not sampled (now edge %0d)", x.tag, x.e, edge_cnt);
            end else if ((obs & x.mask) !== (x.val & x.mask)) begin
                errors++;
                $display("FAIL %s: edge %0d got {rst,c2,c4,c8,cf}=%b expected %b mask %b",
                         x.tag, x.e, obs, x.val, x.mask);
            end
        end
    end

    task automatic push(input int unsigned e, input logic [4:0] m, input logic [4:0] v,
                        input string t);
        exp_t x;
        x.e = e; x.mask = m; x.val = v; x.tag = t;
        q.push_back(x);
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_hold(input int unsigned from, input int unsigned to, input string t);
        for (int unsigned e = from; e <= to; e++) push(e, 5'b11111, 5'b10000, t);
    endtask

    task automatic expect_run(input int unsigned r1_edge, input int unsigned first_r,
                              input int unsigned n, input string t);
        for (int unsigned i = 0; i < n; i++)
            push(r1_edge + i, 5'b11111, {1'b0, tbl[(first_r + i - 1) % 8]}, t);
    endtask

    task automatic expect_frac(input int unsigned from, input int unsigned n, input logic v,
                               input string t);
        for (int unsigned i = 0; i < n; i++) push(from + i, 5'b10001, {4'b0000, v}, t);
    endtask

    initial begin
        int unsigned base, n, r1, m, k, j;
        rst_n = 1'b0; pll_locked = 1'b0; soft_rst = 1'b0; num = 10'd3; den = 10'd8;
        push(1, 5'b11111, 5'b10000, "por");
        push(2, 5'b11111, 5'b10000, "por");
        tick(2);
        rst_n = 1'b1;
        expect_hold(3, 4, "no_lock");
        tick(2);

        // Lock rises: release after edge base+19, then num=3/den=8 over 800 cycles
        pll_locked = 1'b1;
        base = edge_cnt;
        expect_hold(base + 1, base + 18, "hold");
        expect_run(base + 19, 1, 800, "run_3_8");
        tick(818);

        // One-cycle lock drop
        pll_locked = 1'b0;
        tick(1);
        n = edge_cnt;
        pll_locked = 1'b1;
        expect_run(n, 801, 2, "lock_drop_pre");
        expect_hold(n + 2, n + 2 + HC, "lock_drop_hold");
        r1 = n + 3 + HC;
        expect_run(r1, 1, 5, "lock_drop_run");
        tick(r1 + 4 - n);

        // Soft reset mid-sequence (acc and divider non-zero at this point)
        soft_rst = 1'b1;
        tick(1);
        m = edge_cnt;
        soft_rst = 1'b0;
        expect_hold(m, m + HC - 1, "soft_hold");
        expect_run(m + HC, 1, 8, "soft_run");
        tick(HC + 7);

        // Fractional boundaries
        den = 10'd0;
        expect_frac(edge_cnt + 1, 16, 1'b0, "den0");
        tick(16);
        num = 10'd9; den = 10'd8;
        expect_frac(edge_cnt + 1, 16, 1'b1, "num_gt_den");
        tick(16);
        num = 10'd0;
        expect_frac(edge_cnt + 1, 16, 1'b0, "num0");
        tick(16);

        // Asynchronous reset in RUN right after an edge that raised cen2
        num = 10'd3;
        push(edge_cnt + 1, 5'b10000, 5'b00000, "pre_async");
        tick(2);
        rst_n = 1'b0;
        push(edge_cnt, 5'b11111, 5'b10000, "async_run");
        push(edge_cnt + 1, 5'b11111, 5'b10000, "rst_low");
        push(edge_cnt + 2, 5'b11111, 5'b10000, "rst_low");
        tick(2);
        rst_n = 1'b1;
        k = edge_cnt;
        expect_hold(k + 1, k + 8, "rehold");
        tick(8);

        // rst_n pulse between edges while in HOLD restarts from the synchronizer
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        j = edge_cnt;
        expect_hold(j + 1, j + 2 + HC, "hold_rst_hold");
        expect_run(j + 3 + HC, 1, 8, "hold_rst_run");
        tick(HC + 2 + 8 + 2);

        if (q.size() != 0) begin
            $display("FAIL leftover: %0d expectations unchecked, expected 0", q.size());
            errors += q.size();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
